// File: rtl/byte_print_pkg.sv
// byte_print_pkg: shared constants, FSM state type and index-width helper
package byte_print_pkg;
  localparam logic [7:0] NEWLINE = 8'h0A;
  typedef enum logic {IDLE, LOCKED} state_e;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/byte_print_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at/after ptr with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
  end
  assign any = |req;
endmodule

// File: rtl/byte_print_arbiter.sv
// byte_print_arbiter: line-granular round-robin lock sharing one byte printer between sources
module byte_print_arbiter
  import byte_print_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int MAX_LINE = 128,
  parameter int IDLE_TIMEOUT = 64,
  localparam int SW = src_w(N_SRC)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_SRC-1:0]   in_valid,
  input  logic [8*N_SRC-1:0] in_byte,
  output logic [N_SRC-1:0]   in_ready,
  output logic               out_valid,
  output logic [7:0]         out_byte,
  output logic [SW-1:0]      out_src,
  output logic               out_forced
);
  localparam int BW = $clog2(MAX_LINE + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  state_e state, state_nxt;
  logic [SW-1:0] rr_ptr, owner, pick, owner_inc;
  logic [BW-1:0] byte_cnt;
  logic [IW-1:0] idle_cnt;
  logic [7:0] cur_byte;
  logic any, xfer, nl, lim, tmo, rel;
  rr_pick #(.N(N_SRC), .W(SW)) u_pick (.req(in_valid), .ptr(rr_ptr), .any(any), .idx(pick));
  always_comb begin
    cur_byte = in_byte[{owner, 3'b000} +: 8];
    xfer = (state == LOCKED) && in_valid[owner];
    nl = xfer && (cur_byte == NEWLINE);
    lim = xfer && (byte_cnt == BW'(MAX_LINE - 1));
    tmo = (state == LOCKED) && !in_valid[owner] && (idle_cnt == IW'(IDLE_TIMEOUT - 1));
    rel = nl || lim || tmo;
    owner_inc = (owner == SW'(N_SRC - 1)) ? '0 : owner + 1'b1;
  end
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (any ? LOCKED : IDLE) : (rel ? IDLE : LOCKED);
  always_comb
    in_ready = (state == LOCKED) ? (N_SRC'(1) << owner) : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      owner <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      out_valid <= 1'b0;
      out_byte <= '0;
      out_src <= '0;
      out_forced <= 1'b0;
    end else begin
      out_valid <= xfer;
      out_forced <= (lim || tmo) && !nl;
      if (xfer) begin
        out_byte <= cur_byte;
        out_src <= owner;
      end
      if (state == IDLE) begin
        if (any) begin
          owner <= pick;
          byte_cnt <= '0;
          idle_cnt <= '0;
        end
      end else begin
        if (rel) rr_ptr <= owner_inc;
        byte_cnt <= xfer ? byte_cnt + 1'b1 : byte_cnt;
        idle_cnt <= xfer ? '0 : idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_byte_print_arbiter.sv
// tb_byte_print_arbiter: directed checks of locking, limits, timeout, reset and fairness
module tb_byte_print_arbiter;
  logic clk, reset_n;
  logic [3:0] in_valid, in_ready;
  logic [7:0] bytes [4];
  logic [31:0] in_byte;
  logic out_valid, out_forced;
  logic [7:0] out_byte;
  logic [1:0] out_src;
  int total = 0, bad = 0;
  assign in_byte = {bytes[3], bytes[2], bytes[1], bytes[0]};
  byte_print_arbiter #(.N_SRC(4), .MAX_LINE(4), .IDLE_TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .out_valid(out_valid), .out_byte(out_byte),
    .out_src(out_src), .out_forced(out_forced)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic xs(input logic [1:0] s, input logic [7:0] b, input logic f, input string tag);
    bytes[s] = b;
    chk({tag, ".r"}, in_ready, 4'b1 << s);
    cyc;
    chk({tag, ".v"}, out_valid, 1);
    chk({tag, ".b"}, out_byte, b);
    chk({tag, ".s"}, out_src, s);
    chk({tag, ".f"}, out_forced, f);
  endtask
  initial begin
    reset_n = 1'b0;
    in_valid = '0;
    for (int i = 0; i < 4; i++) bytes[i] = '0;
    cyc;
    cyc;
    chk("rst.v", out_valid, 0);
    chk("rst.b", out_byte, 0);
    chk("rst.s", out_src, 0);
    chk("rst.f", out_forced, 0);
    chk("rst.r", in_ready, 0);
    reset_n = 1'b1;
    in_valid = 4'b0010;
    bytes[1] = "h";
    cyc;
    chk("t1.grant", in_ready, 4'b0010);
    chk("t1.nov", out_valid, 0);
    xs(1, "h", 0, "t1h");
    xs(1, "i", 0, "t1i");
    xs(1, 8'h0A, 0, "t1nl");
    in_valid = '0;
    chk("t1.rel", in_ready, 0);
    cyc;
    chk("t1.idle", out_valid, 0);
    reset_n = 1'b0;
    in_valid = 4'b0101;
    bytes[0] = "a";
    bytes[2] = "a";
    cyc;
    reset_n = 1'b1;
    chk("t2.rst", in_ready, 0);
    cyc;
    chk("t2.g0", in_ready, 4'b0001);
    xs(0, "a", 0, "t2a0");
    xs(0, "b", 0, "t2b0");
    xs(0, 8'h0A, 0, "t2n0");
    in_valid[0] = 1'b0;
    chk("t2.rel0", in_ready, 0);
    cyc;
    chk("t2.bub", out_valid, 0);
    chk("t2.g2", in_ready, 4'b0100);
    xs(2, "a", 0, "t2a2");
    xs(2, "b", 0, "t2b2");
    xs(2, 8'h0A, 0, "t2n2");
    in_valid = '0;
    in_valid = 4'b1000;
    bytes[3] = "A";
    cyc;
    chk("t3.g", in_ready, 4'b1000);
    xs(3, "A", 0, "t3A");
    xs(3, "B", 0, "t3B");
    xs(3, "C", 0, "t3C");
    xs(3, "D", 1, "t3D");
    chk("t3.rel", in_ready, 0);
    cyc;
    chk("t3.bubv", out_valid, 0);
    chk("t3.bubf", out_forced, 0);
    chk("t3.g2", in_ready, 4'b1000);
    xs(3, "E", 0, "t3E");
    xs(3, "F", 0, "t3F");
    xs(3, 8'h0A, 0, "t3nl");
    in_valid = 4'b0011;
    bytes[0] = "x";
    bytes[1] = "y";
    cyc;
    chk("t4.g0", in_ready, 4'b0001);
    xs(0, "x", 0, "t4x");
    in_valid[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc;
      chk("t4.wv", out_valid, 0);
      chk("t4.wf", out_forced, 0);
      chk("t4.wr", in_ready, 4'b0001);
    end
    cyc;
    chk("t4.tf", out_forced, 1);
    chk("t4.tv", out_valid, 0);
    chk("t4.tr", in_ready, 0);
    cyc;
    chk("t4.g1", in_ready, 4'b0010);
    chk("t4.f0", out_forced, 0);
    xs(1, "y", 0, "t4y");
    xs(1, 8'h0A, 0, "t4nl");
    in_valid = 4'b1001;
    bytes[0] = "r";
    bytes[3] = "q";
    cyc;
    chk("t5.g3", in_ready, 4'b1000);
    xs(3, "q", 0, "t5q");
    reset_n = 1'b0;
    cyc;
    reset_n = 1'b1;
    chk("t5.v", out_valid, 0);
    chk("t5.r", in_ready, 0);
    chk("t5.s", out_src, 0);
    cyc;
    chk("t5.g0", in_ready, 4'b0001);
    chk("t5.v2", out_valid, 0);
    xs(0, "r", 0, "t5r");
    xs(0, 8'h0A, 0, "t5nl");
    in_valid = 4'b0101;
    bytes[2] = "a";
    bytes[0] = "z";
    cyc;
    chk("t6.g2", in_ready, 4'b0100);
    xs(2, "a", 0, "t6a");
    xs(2, "b", 0, "t6b");
    xs(2, "c", 0, "t6c");
    xs(2, 8'h0A, 0, "t6nl");
    chk("t6.rel", in_ready, 0);
    cyc;
    chk("t6.g0", in_ready, 4'b0001);
    chk("t6.f", out_forced, 0);
    xs(0, "z", 0, "t6z");
    xs(0, 8'h0A, 0, "t6nl0");
    in_valid = '0;
    cyc;
    chk("t6.end", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
